// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
//   XLEN          : datapath width
//   NOP_INST      : canonical NOP (addi x0, x0, 0), used for bubbles and flushed slots
//   fetch_entry_t : {pc, inst} pair held in the instruction buffer
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the fetch pc queue and the instruction buffer.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   push, din     : write enable and data
//   pop, dout     : read enable and head data (dout valid whenever !empty)
//   clear         : drop all contents; overrides push and pop
//   count         : number of stored entries (0..DEPTH)
//   full, empty   : status flags
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count/empty gate every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

    always @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage RISC-V pipeline.
// Owns the fetch PC, issues requests to an in-order variable-latency instruction
// memory, buffers returned words and drives the IF/ID register. Taken branches from
// ID flush the stage; responses to requests issued before the redirect are dropped.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt : request handshake (address held until granted)
//   imem_rvalid/imem_rdata      : in-order response
//   pc_src, pc_branch           : redirect from ID
//   stall                       : hold IF/ID
//   IF_ID_pc/inst/rs1/rs2/valid : IF/ID register (NOP when not valid)
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] pc_branch,
    input  logic        stall,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic [4:0]  IF_ID_rs1,
    output logic [4:0]  IF_ID_rs2,
    output logic        IF_ID_valid
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic          grant;
    logic          redirect;
    logic          resp_live;
    logic          resp_drop;
    logic          bypass;

    logic          pcq_push, pcq_pop, pcq_full, pcq_empty;
    logic [31:0]   pcq_head;
    logic [CW-1:0] pcq_count;

    logic          buf_push, buf_pop, buf_full, buf_empty;
    fetch_entry_t  buf_in, buf_head;
    logic [CW-1:0] buf_count;

    // A request needs a buffer slot reserved for its response, so buffered
    // words and in-flight requests together never exceed BUF_DEPTH.
    assign imem_req  = !reset && !pc_src && (drop_cnt == '0)
                       && ((outstanding + buf_count) < CW'(BUF_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign redirect  = pc_src && !stall;
    assign resp_drop = imem_rvalid && (drop_cnt != '0);
    assign resp_live = imem_rvalid && (drop_cnt == '0);

    // An empty buffer lets a live response go straight into IF/ID.
    assign bypass    = !stall && !redirect && buf_empty && resp_live;
    assign buf_pop   = !stall && !redirect && !buf_empty;
    assign buf_push  = resp_live && !redirect && !bypass;
    assign buf_in    = '{pc: pcq_head, inst: imem_rdata};

    assign pcq_push  = grant;
    assign pcq_pop   = resp_live && !redirect && !pcq_empty;

    fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .push  (pcq_push),
        .din   (fetch_pc),
        .pop   (pcq_pop),
        .dout  (pcq_head),
        .clear (redirect),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .din   (buf_in),
        .pop   (buf_pop),
        .dout  (buf_head),
        .clear (redirect),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (redirect) begin
                fetch_pc <= pc_branch;
                // Everything still in flight is stale; a response arriving now
                // is discarded on the spot, so it is not counted again.
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else begin
                if (grant)     fetch_pc <= fetch_pc + 32'd4;
                if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_pc    <= '0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_rs1   <= '0;
            IF_ID_rs2   <= '0;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                IF_ID_pc    <= pc_branch;
                IF_ID_inst  <= NOP_INST;
                IF_ID_rs1   <= '0;
                IF_ID_rs2   <= '0;
                IF_ID_valid <= 1'b0;
            end else if (buf_pop) begin
                IF_ID_pc    <= buf_head.pc;
                IF_ID_inst  <= buf_head.inst;
                IF_ID_rs1   <= buf_head.inst[19:15];
                IF_ID_rs2   <= buf_head.inst[24:20];
                IF_ID_valid <= 1'b1;
            end else if (bypass) begin
                IF_ID_pc    <= pcq_head;
                IF_ID_inst  <= imem_rdata;
                IF_ID_rs1   <= imem_rdata[19:15];
                IF_ID_rs2   <= imem_rdata[24:20];
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_inst  <= NOP_INST;
                IF_ID_rs1   <= '0;
                IF_ID_rs2   <= '0;
                IF_ID_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (32'(pcq_count) + 32'(drop_cnt) == 32'(outstanding));
            assert (!(grant && pcq_full));
            assert (!(buf_push && buf_full && !buf_pop));
            assert (!(resp_live && pcq_empty));
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        stall;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        IF_ID_valid;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_src      (pc_src),
        .pc_branch   (pc_branch),
        .stall       (stall),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_rs1   (IF_ID_rs1),
        .IF_ID_rs2   (IF_ID_rs2),
        .IF_ID_valid (IF_ID_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle, the combinational request expected
    // before the edge, and the IF/ID contents expected after it.
    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        pc_src;
        logic [31:0] pc_branch;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic st, input logic ps, input logic [31:0] pb,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.pc_src = ps;
        v.pc_branch = pb; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
        v.exp_pc = ep; v.exp_inst = ei;
        return v;
    endfunction

    // Memory contents for the randomized phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 13) ^ (a * 32'd7) ^ 32'h0000_00A5;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc;
    logic [31:0] exp_pc;
    logic        hold_addr;
    logic [31:0] held_addr;
    int          n_valid;

    task automatic model_init();
        mq.delete();
        cyc       = 0;
        exp_pc    = RESET_PC;
        hold_addr = 1'b0;
        held_addr = '0;
        n_valid   = 0;
    endtask

    task automatic idle_inputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pc_src      = 1'b0;
        pc_branch   = '0;
        stall       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_init();
    endtask

    // Randomized traffic against an order-level model: instructions must leave
    // IF/ID in program order from the current target, each word matching memory.
    task automatic run_random(input int n);
        logic        req_s;
        logic [31:0] addr_s;
        logic        pv;
        logic [31:0] ppc;
        logic [31:0] pinst;
        logic [31:0] w;
        for (int c = 0; c < n; c++) begin
            imem_gnt  = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 4) == 0);
            pc_src    = ($urandom_range(0, 19) == 0);
            pc_branch = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4
                                                    : (32'($urandom_range(0, 1023)) << 2);
            imem_rvalid = (mq.size() > 0) && (mq[0].ready <= cyc);
            imem_rdata  = imem_rvalid ? mem_word(mq[0].addr) : $urandom;
            #1;
            req_s  = imem_req;
            addr_s = imem_addr;
            pv     = IF_ID_valid;
            ppc    = IF_ID_pc;
            pinst  = IF_ID_inst;
            if (hold_addr) check("addr_held", addr_s, held_addr);
            if (req_s) check("addr_aligned", {30'd0, addr_s[1:0]}, 32'd0);
            @(posedge clk);
            #1;
            if (imem_rvalid) void'(mq.pop_front());
            if (req_s && imem_gnt) mq.push_back('{addr: addr_s, ready: cyc + $urandom_range(1, 4)});
            check("outstanding_bound", 32'(mq.size() <= BUF_DEPTH), 32'd1);
            hold_addr = req_s && !imem_gnt && !pc_src;
            held_addr = addr_s;
            if (stall) begin
                check("stall_valid", {31'd0, IF_ID_valid}, {31'd0, pv});
                check("stall_pc", IF_ID_pc, ppc);
                check("stall_inst", IF_ID_inst, pinst);
            end else if (pc_src) begin
                check("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
                check("flush_pc", IF_ID_pc, pc_branch);
                check("flush_inst", IF_ID_inst, NOP);
                exp_pc = pc_branch;
            end else if (IF_ID_valid) begin
                w = mem_word(exp_pc);
                check("rand_pc", IF_ID_pc, exp_pc);
                check("rand_inst", IF_ID_inst, w);
                check("rand_rs1", {27'd0, IF_ID_rs1}, {27'd0, w[19:15]});
                check("rand_rs2", {27'd0, IF_ID_rs2}, {27'd0, w[24:20]});
                exp_pc = exp_pc + 32'd4;
                n_valid++;
            end else begin
                check("bubble_inst", IF_ID_inst, NOP);
                check("bubble_pc", IF_ID_pc, ppc);
                check("bubble_rs", {22'd0, IF_ID_rs1, IF_ID_rs2}, 32'd0);
            end
            cyc++;
            @(negedge clk);
        end
        check("liveness", 32'(n_valid >= n / 8), 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h000, 0, 32'h000, NOP);
        vecs[1]  = mk(1, 1, 32'hA5,  0, 0, 32'h0,   1, 32'h004, 1, 32'h000, 32'hA5);
        vecs[2]  = mk(1, 1, 32'hA1,  0, 0, 32'h0,   1, 32'h008, 1, 32'h004, 32'hA1);
        vecs[3]  = mk(0, 1, 32'hAD,  0, 0, 32'h0,   1, 32'h00C, 1, 32'h008, 32'hAD);
        vecs[4]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h00C, 0, 32'h008, NOP);
        vecs[5]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h00C, 0, 32'h008, NOP);
        vecs[6]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h010, 0, 32'h008, NOP);
        vecs[7]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h014, 0, 32'h008, NOP);
        vecs[8]  = mk(1, 1, 32'hA9,  0, 1, 32'h100, 0, 32'h014, 0, 32'h100, NOP);
        vecs[9]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h100, 0, 32'h100, NOP);
        vecs[10] = mk(1, 1, 32'hB5,  0, 0, 32'h0,   0, 32'h100, 0, 32'h100, NOP);
        vecs[11] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h100, NOP);
        vecs[12] = mk(0, 1, 32'h1A5, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 32'h1A5);
        vecs[13] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 0, 32'h100, NOP);
        vecs[14] = mk(1, 1, 32'h1A1, 0, 0, 32'h0,   1, 32'h108, 1, 32'h104, 32'h1A1);
        vecs[15] = mk(1, 1, 32'h1AD, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104, 32'h1A1);
        vecs[16] = mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h110, 1, 32'h104, 32'h1A1);
        vecs[17] = mk(1, 1, 32'h1A9, 1, 0, 32'h0,   0, 32'h110, 1, 32'h104, 32'h1A1);
        vecs[18] = mk(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h110, 1, 32'h108, 32'h1AD);
        vecs[19] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h110, 1, 32'h10C, 32'h1A9);
        vecs[20] = mk(0, 1, 32'h1B5, 0, 0, 32'h0,   1, 32'h114, 1, 32'h110, 32'h1B5);
        vecs[21] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h114, 0, 32'h110, NOP);

        // Reset state
        reset = 1'b1;
        idle_inputs();
        model_init();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", {31'd0, imem_req}, 32'd0);
        check("reset_inst", IF_ID_inst, NOP);
        check("reset_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("reset_pc", IF_ID_pc, 32'd0);
        check("reset_rs", {22'd0, IF_ID_rs1, IF_ID_rs2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_req", {31'd0, imem_req}, 32'd1);
        check("release_addr", imem_addr, RESET_PC);

        // Directed stream, redirect with two in flight, stall
        for (int i = 0; i < NV; i++) begin
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            stall       = vecs[i].stall;
            pc_src      = vecs[i].pc_src;
            pc_branch   = vecs[i].pc_branch;
            #1;
            check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, IF_ID_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_pc", i), IF_ID_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i), IF_ID_inst, vecs[i].exp_inst);
            check($sformatf("vec%0d_rs", i), {22'd0, IF_ID_rs1, IF_ID_rs2},
                  {22'd0, vecs[i].exp_inst[19:15], vecs[i].exp_inst[24:20]});
            @(negedge clk);
        end

        // Grant withheld for 5 cycles: address held, IF/ID bubbles with pc held
        do_reset();
        imem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("nogrant_addr", imem_addr, RESET_PC + 32'd4);
            check("nogrant_req", {31'd0, imem_req}, 32'd1);
            @(posedge clk);
            #1;
            check("nogrant_valid", {31'd0, IF_ID_valid}, 32'd0);
            check("nogrant_pc", IF_ID_pc, RESET_PC);
            @(negedge clk);
        end

        // Randomized traffic
        do_reset();
        run_random(3000);

        // Asynchronous reset between grant and response
        do_reset();
        imem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0012_8093;
        @(posedge clk);
        #1;
        check("pre_areset_valid", {31'd0, IF_ID_valid}, 32'd1);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("areset_req", {31'd0, imem_req}, 32'd0);
        check("areset_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("areset_inst", IF_ID_inst, NOP);
        check("areset_pc", IF_ID_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_init();
        #1;
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        @(negedge clk);
        run_random(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
